// File: rtl/det3x3_seq_engine_pkg.sv
// Shared types and the cofactor-expansion step table for the 3x3 determinant engine.
package det3_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  // Step / element index, 0..8.
  typedef logic [3:0] step_t;

  localparam int    NUM_ELEM = 9;
  localparam step_t LAST_IDX = 4'(NUM_ELEM - 1);
  // Operand-B select value that routes the minor register instead of an element.
  localparam step_t SEL_M    = 4'd9;

  typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB} op_t;

  typedef struct packed {
    step_t a_sel;   // element index for operand A
    step_t b_sel;   // element index for operand B, or SEL_M
    logic  to_acc;  // 1 = update result register, 0 = update minor register
    op_t   op;
  } step_cfg_t;

  // Elements are a..i = 0..8. Three minors, each folded into the result:
  //   m=e*i; m-=f*h; acc=a*m; m=d*i; m-=f*g; acc-=b*m; m=d*h; m-=e*g; acc+=c*m
  function automatic step_cfg_t step_cfg(input step_t s);
    step_cfg_t c;
    case (s)
      4'd0:    c = '{a_sel: 4'd4, b_sel: 4'd8,  to_acc: 1'b0, op: OP_LOAD};
      4'd1:    c = '{a_sel: 4'd5, b_sel: 4'd7,  to_acc: 1'b0, op: OP_SUB};
      4'd2:    c = '{a_sel: 4'd0, b_sel: SEL_M, to_acc: 1'b1, op: OP_LOAD};
      4'd3:    c = '{a_sel: 4'd3, b_sel: 4'd8,  to_acc: 1'b0, op: OP_LOAD};
      4'd4:    c = '{a_sel: 4'd5, b_sel: 4'd6,  to_acc: 1'b0, op: OP_SUB};
      4'd5:    c = '{a_sel: 4'd1, b_sel: SEL_M, to_acc: 1'b1, op: OP_SUB};
      4'd6:    c = '{a_sel: 4'd3, b_sel: 4'd7,  to_acc: 1'b0, op: OP_LOAD};
      4'd7:    c = '{a_sel: 4'd4, b_sel: 4'd6,  to_acc: 1'b0, op: OP_SUB};
      4'd8:    c = '{a_sel: 4'd2, b_sel: SEL_M, to_acc: 1'b1, op: OP_ADD};
      default: c = '{a_sel: 4'd0, b_sel: 4'd0,  to_acc: 1'b0, op: OP_LOAD};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/det3x3_seq_engine_mul_acc.sv
// Single shared multiplier feeding a minor register and a result accumulator.
// All arithmetic is modulo 2^DET_W, so one datapath serves signed and unsigned.
module det3_mul_acc
  import det3_pkg::*;
#(
  parameter int DET_W = 27
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             en_i,
  input  step_t                            step_i,
  input  logic [NUM_ELEM-1:0][DET_W-1:0]   elem_i,
  output logic [DET_W-1:0]                 acc_d_o
);

  step_cfg_t        cfg;
  logic [DET_W-1:0] opa, opb, prod, tgt, res;
  logic [DET_W-1:0] m_q, m_d, acc_q, acc_d;

  // Decode the current step, multiply, and combine into the selected register.
  always_comb begin
    cfg  = step_cfg(step_i);
    opa  = elem_i[cfg.a_sel];
    opb  = (cfg.b_sel == SEL_M) ? m_q : elem_i[cfg.b_sel];
    prod = opa * opb;
    tgt  = cfg.to_acc ? acc_q : m_q;
    res  = prod;
    case (cfg.op)
      OP_ADD:  res = tgt + prod;
      OP_SUB:  res = tgt - prod;
      default: res = prod;
    endcase
    m_d   = m_q;
    acc_d = acc_q;
    if (en_i) begin
      if (cfg.to_acc) acc_d = res;
      else            m_d   = res;
    end
  end

  // Minor and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q   <= '0;
      acc_q <= '0;
    end else begin
      m_q   <= m_d;
      acc_q <= acc_d;
    end
  end

  // The final step's sum is exposed so the top can register it alongside done.
  assign acc_d_o = acc_d;

endmodule

// File: rtl/det3x3_seq_engine.sv
// Fetches a row-major 3x3 matrix from word memory, then computes its
// determinant by cofactor expansion on one shared multiplier.
module det3x3_seq_engine
  import det3_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 4,
  parameter int MEM_LAT = 0,
  parameter int DET_W   = 3*DW+3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             signed_mode_i,
  input  logic [AW-1:0]    start_addr_i,
  input  logic [DW-1:0]    mem_data_i,
  output logic [AW-1:0]    mem_addr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [DET_W-1:0] det_o
);

  if (DET_W < 3*DW+3) begin : g_bad_det_w
    $error("det3x3_seq_engine: DET_W must be at least 3*DW+3");
  end
  if (MEM_LAT != 0 && MEM_LAT != 1) begin : g_bad_mem_lat
    $error("det3x3_seq_engine: MEM_LAT must be 0 or 1");
  end

  state_t           state_q, state_d;
  step_t            step_q, issue_q, cap_q;
  logic [AW-1:0]    addr_q;
  logic             signed_q;
  logic [DET_W-1:0] det_q;
  logic             done_q;

  logic             accept, issue_v, cap_v, calc_en, finish;
  logic [DET_W-1:0] ext_data, acc_d;
  logic [NUM_ELEM-1:0][DET_W-1:0] elem_w;

  // An address goes out every LOAD cycle until all nine have been issued.
  assign issue_v = (state_q == LOAD) && (issue_q != 4'(NUM_ELEM));

  // Read data for an issued address arrives MEM_LAT cycles later.
  if (MEM_LAT == 0) begin : g_lat0
    assign cap_v = issue_v;
  end else begin : g_latn
    logic [MEM_LAT-1:0] lat_q;
    // Capture-valid delay line matching the memory read latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lat_q <= '0;
      else         lat_q <= (lat_q << 1) | (MEM_LAT)'(issue_v);
    end
    assign cap_v = lat_q[MEM_LAT-1];
  end

  assign ext_data = signed_q ? {{(DET_W-DW){mem_data_i[DW-1]}}, mem_data_i}
                             : {{(DET_W-DW){1'b0}}, mem_data_i};

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and control strobes; a start in DONE chains straight into LOAD.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    calc_en = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cap_v && cap_q == LAST_IDX) state_d = CALC;
      end
      CALC: begin
        calc_en = 1'b1;
        if (step_q == LAST_IDX) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address, counters and latched request fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      issue_q  <= '0;
      cap_q    <= '0;
      step_q   <= '0;
      signed_q <= 1'b0;
    end else if (accept) begin
      addr_q   <= start_addr_i;
      issue_q  <= '0;
      cap_q    <= '0;
      step_q   <= '0;
      signed_q <= signed_mode_i;
    end else begin
      if (issue_v) begin
        addr_q  <= addr_q + 1'b1;
        issue_q <= issue_q + 1'b1;
      end
      if (cap_v)   cap_q  <= cap_q + 1'b1;
      if (calc_en) step_q <= step_q + 1'b1;
    end
  end

  // Element registers a..i, each loaded when the capture index reaches it.
  for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_elem
    logic [DET_W-1:0] e_q;
    // Capture the extended read word for element gi.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                              e_q <= '0;
      else if (cap_v && cap_q == step_t'(gi))   e_q <= ext_data;
    end
    assign elem_w[gi] = e_q;
  end

  det3_mul_acc #(.DET_W(DET_W)) u_mul_acc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (calc_en),
    .step_i  (step_q),
    .elem_i  (elem_w),
    .acc_d_o (acc_d)
  );

  // Result and done pulse update on the same edge as the final step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      det_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) det_q <= acc_d;
    end
  end

  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q == LOAD) || (state_q == CALC);
  assign done_o     = done_q;
  assign det_o      = det_q;

endmodule

// File: tb/tb_det3x3_seq_engine.sv
// Scoreboard bench: one engine with combinational memory read, one with registered read.
module tb_det3x3_seq_engine;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DET_W = 3*DW+3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start0, start1, sgn;
  logic [AW-1:0]    saddr;
  logic [DW-1:0]    mem [16];
  logic [AW-1:0]    addr0, addr1;
  logic [DW-1:0]    rdata0, rdata1;
  logic             busy0, busy1, done0, done1;
  logic [DET_W-1:0] det0, det1;

  assign rdata0 = mem[addr0];
  always @(posedge clk) rdata1 <= mem[addr1];

  det3x3_seq_engine #(.DW(DW), .AW(AW), .MEM_LAT(0), .DET_W(DET_W)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .signed_mode_i(sgn),
    .start_addr_i(saddr), .mem_data_i(rdata0), .mem_addr_o(addr0),
    .busy_o(busy0), .done_o(done0), .det_o(det0)
  );

  det3x3_seq_engine #(.DW(DW), .AW(AW), .MEM_LAT(1), .DET_W(DET_W)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .signed_mode_i(sgn),
    .start_addr_i(saddr), .mem_data_i(rdata1), .mem_addr_o(addr1),
    .busy_o(busy1), .done_o(done1), .det_o(det1)
  );

  int               checks = 0;
  int               passed = 0;
  logic [DET_W-1:0] exp_q0[$];
  logic [DET_W-1:0] exp_q1[$];
  logic [DW-1:0]    mat [9];

  // Reference: direct cofactor formula in 64-bit integers, truncated to DET_W.
  function automatic logic [DET_W-1:0] model_det(input logic [DW-1:0] m [9], input logic s);
    longint v [9];
    longint r;
    for (int k = 0; k < 9; k++) v[k] = s ? longint'($signed(m[k])) : longint'(m[k]);
    r = v[0]*(v[4]*v[8] - v[5]*v[7]) - v[1]*(v[3]*v[8] - v[5]*v[6]) + v[2]*(v[3]*v[7] - v[4]*v[6]);
    return r[DET_W-1:0];
  endfunction

  task automatic put_mat(input logic [AW-1:0] a);
    for (int k = 0; k < 9; k++) begin
      logic [AW-1:0] idx;
      idx = a + AW'(k);
      mem[idx] = mat[k];
    end
  endtask

  // Pulse start for one cycle and push the expected result; returns at the negedge after the sampling edge.
  task automatic start_run(input int which, input logic s, input logic [AW-1:0] a, input logic [DET_W-1:0] e);
    @(negedge clk);
    sgn = s;
    saddr = a;
    if (which == 0) begin start0 = 1'b1; exp_q0.push_back(e); end
    else            begin start1 = 1'b1; exp_q1.push_back(e); end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Count rising edges until done is seen (sampled 1 time unit after the edge); -1 on timeout.
  task automatic wait_done(input int which, input int max_cyc, output int lat);
    lat = -1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge clk);
      #1;
      if (((which == 0) ? done0 : done1) === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else passed++;
    checks++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b want 0", done0); else passed++;
    checks++; if (det0 !== '0) $display("FAIL reset_det: got %0d want 0", det0); else passed++;
    checks++; if (addr0 !== '0) $display("FAIL reset_addr: got %h want 0", addr0); else passed++;
    checks++; if (det1 !== '0) $display("FAIL reset_det_lat1: got %0d want 0", det1); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy0); else passed++;
  endtask

  task automatic test_identity();
    int lat;
    logic [DET_W-1:0] want;
    mat = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    put_mat(4'h0);
    start_run(0, 1'b0, 4'h0, 27'd1);
    checks++; if (busy0 !== 1'b1) $display("FAIL identity_busy: got %b want 1", busy0); else passed++;
    wait_done(0, 40, lat);
    want = exp_q0.pop_front();
    checks++; if (lat !== 18) $display("FAIL identity_latency: got %0d cycles want 18", lat); else passed++;
    checks++; if (det0 !== want) $display("FAIL identity_det: got %0d want %0d", det0, want); else passed++;
  endtask

  task automatic test_signed_unsigned();
    int lat;
    logic [DET_W-1:0] want;
    mat = '{8'd2, 8'hFD, 8'd1, 8'd2, 8'd0, 8'hFF, 8'd1, 8'd4, 8'd5};
    put_mat(4'h0);
    start_run(0, 1'b1, 4'h0, 27'd49);
    wait_done(0, 40, lat);
    want = exp_q0.pop_front();
    checks++; if (lat !== 18) $display("FAIL signed_latency: got %0d want 18", lat); else passed++;
    checks++; if (det0 !== want) $display("FAIL signed_det: got %0d want %0d", det0, want); else passed++;
    start_run(0, 1'b0, 4'h0, 27'd59953);
    wait_done(0, 40, lat);
    want = exp_q0.pop_front();
    checks++; if (lat !== 18) $display("FAIL unsigned_latency: got %0d want 18", lat); else passed++;
    checks++; if (det0 !== want) $display("FAIL unsigned_det: got %0d want %0d", det0, want); else passed++;
  endtask

  task automatic test_extremes();
    int lat;
    logic [DET_W-1:0] want;
    mat = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255};
    put_mat(4'h0);
    start_run(0, 1'b0, 4'h0, 27'd16581375);
    wait_done(0, 40, lat);
    want = exp_q0.pop_front();
    checks++; if (lat !== 18) $display("FAIL diag255_latency: got %0d want 18", lat); else passed++;
    checks++; if (det0 !== want) $display("FAIL diag255_det: got %0d want %0d", det0, want); else passed++;
    for (int k = 0; k < 9; k++) mat[k] = 8'd255;
    put_mat(4'h0);
    start_run(0, 1'b0, 4'h0, 27'd0);
    wait_done(0, 40, lat);
    want = exp_q0.pop_front();
    checks++; if (lat !== 18) $display("FAIL all255_latency: got %0d want 18", lat); else passed++;
    checks++; if (det0 !== want) $display("FAIL all255_det: got %0d want %0d", det0, want); else passed++;
  endtask

  task automatic test_addr_wrap();
    int lat;
    logic [DET_W-1:0] want;
    logic [AW-1:0] ea;
    mat = '{8'd2, 8'hFD, 8'd1, 8'd2, 8'd0, 8'hFF, 8'd1, 8'd4, 8'd5};
    for (int k = 0; k < 16; k++) mem[k] = 8'h00;
    put_mat(4'hC);
    start_run(0, 1'b0, 4'hC, model_det(mat, 1'b0));
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      ea = 4'hC + AW'(k);
      checks++; if (addr0 !== ea) $display("FAIL wrap_addr%0d: got %h want %h", k, addr0, ea); else passed++;
    end
    wait_done(0, 40, lat);
    want = exp_q0.pop_front();
    checks++; if (lat !== 10) $display("FAIL wrap_latency: got %0d want 10 more edges", lat); else passed++;
    checks++; if (det0 !== want) $display("FAIL wrap_det: got %0d want %0d", det0, want); else passed++;
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    logic [DET_W-1:0] want;
    mat = '{8'd2, 8'hFD, 8'd1, 8'd2, 8'd0, 8'hFF, 8'd1, 8'd4, 8'd5};
    put_mat(4'h0);
    start_run(0, 1'b1, 4'h0, 27'd49);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    want = exp_q0.pop_front();
    checks++; if (busy0 !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy0); else passed++;
    checks++; if (done0 !== 1'b0) $display("FAIL midreset_done: got %b want 0", done0); else passed++;
    checks++; if (det0 !== '0) $display("FAIL midreset_det: got %0d want 0", det0); else passed++;
    checks++; if (addr0 !== '0) $display("FAIL midreset_addr: got %h want 0", addr0); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(0, 25, lat);
    checks++; if (lat !== -1) $display("FAIL midreset_no_done: got done after %0d want none", lat); else passed++;
    start_run(0, 1'b1, 4'h0, want);
    wait_done(0, 40, lat);
    want = exp_q0.pop_front();
    checks++; if (lat !== 18) $display("FAIL midreset_rerun_latency: got %0d want 18", lat); else passed++;
    checks++; if (det0 !== want) $display("FAIL midreset_rerun_det: got %0d want %0d", det0, want); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, tot;
    logic [DET_W-1:0] want;
    mat = '{8'd2, 8'hFD, 8'd1, 8'd2, 8'd0, 8'hFF, 8'd1, 8'd4, 8'd5};
    put_mat(4'h0);
    start_run(1, 1'b1, 4'h0, 27'd49);
    // start during LOAD is ignored; mode/address changes must not leak in
    @(negedge clk);
    start1 = 1'b1;
    sgn = 1'b0;
    saddr = 4'h5;
    @(negedge clk);
    start1 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    mat = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255};
    put_mat(4'h0);
    saddr = 4'h0;
    wait_done(1, 20, lat);
    tot = (lat < 0) ? -1 : lat + 14;
    want = exp_q1.pop_front();
    checks++; if (tot !== 19) $display("FAIL lat1_latency: got %0d want 19", tot); else passed++;
    checks++; if (det1 !== want) $display("FAIL lat1_det: got %0d want %0d", det1, want); else passed++;
    // start in the DONE cycle
    start1 = 1'b1;
    exp_q1.push_back(27'd16581375);
    @(posedge clk);
    #1;
    start1 = 1'b0;
    checks++; if (busy1 !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy1); else passed++;
    wait_done(1, 40, lat);
    want = exp_q1.pop_front();
    checks++; if (lat !== 19) $display("FAIL b2b_latency: got %0d want 19", lat); else passed++;
    checks++; if (det1 !== want) $display("FAIL b2b_det: got %0d want %0d", det1, want); else passed++;
    wait_done(1, 25, lat);
    checks++; if (lat !== -1) $display("FAIL b2b_no_extra_done: got done after %0d want none", lat); else passed++;
  endtask

  task automatic test_random();
    int lat, which, want_lat;
    logic s;
    logic [AW-1:0] a;
    logic [DET_W-1:0] want, got;
    for (int i = 0; i < 1100; i++) begin
      which = (i < 1000) ? 0 : 1;
      want_lat = 18 + which;
      s = 1'($urandom);
      a = AW'($urandom);
      for (int k = 0; k < 9; k++) mat[k] = DW'($urandom);
      put_mat(a);
      start_run(which, s, a, model_det(mat, s));
      wait_done(which, 40, lat);
      want = (which == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      got  = (which == 0) ? det0 : det1;
      checks++; if (lat !== want_lat) $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, want_lat); else passed++;
      checks++; if (got !== want) $display("FAIL rand%0d_det: got %0d want %0d (signed=%b addr=%h)", i, got, want, s, a); else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    sgn = 1'b0;
    saddr = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    test_reset();
    test_identity();
    test_signed_unsigned();
    test_addr_wrap();
    test_reset_mid_calc();
    test_extremes();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
